// File: rtl/md_sequencer_if.sv
// Bus between the E-stage pipeline and the multiply/divide sequencer.
// The pipeline side (master) presents an MD op plus operands and sees
// start/busy/stall and the HI/LO registers. The sequencer side (slave)
// takes the op and drives the status and register outputs.
// Handshake: the pipeline asserts op_valid and holds op/D1/D2 stable
// until start (or, for mthi/mtlo, the accept edge); an op shown while
// busy is 1 is ignored and accepted on the first cycle busy is 0 again.
interface md_sequencer_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] D1;
    logic [31:0] D2;
    logic        exc_int;
    logic        md_use_D;
    logic        start;
    logic        busy;
    logic        stall_md;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output op_valid, op, D1, D2, exc_int, md_use_D,
        input  start, busy, stall_md, HI, LO
    );

    modport slave (
        input  op_valid, op, D1, D2, exc_int, md_use_D,
        output start, busy, stall_md, HI, LO
    );
endinterface

// File: rtl/md_sequencer.sv
// E-stage controller for the shared multiply/divide unit and HI/LO.
// The result is computed on the accept cycle and buffered; the unit then
// reports busy for a fixed latency and commits HI/LO on the last busy
// cycle, so the new values are visible the cycle busy falls.
module md_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wr_en;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic        acc;
    logic        is_md;
    logic [63:0] prod_u;
    logic signed [63:0] prod_s;
    logic [63:0] prod;
    logic        div_ok;
    logic        div_ovf;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;

    // Accept only in IDLE, without a flush, for a defined op code.
    assign acc   = bus.op_valid & ~bus.exc_int & (state == IDLE) & (bus.op <= 3'd5);
    assign is_md = (bus.op <= 3'd3);

    assign bus.start    = reset & acc & is_md;
    assign bus.busy     = (state == RUN);
    assign bus.stall_md = reset & bus.md_use_D & (bus.start | bus.busy);
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;

    // 64-bit product; op[0] selects unsigned (multu).
    always_comb begin
        prod_u = {32'b0, bus.D1} * {32'b0, bus.D2};
        prod_s = $signed({{32{bus.D1[31]}}, bus.D1}) * $signed({{32{bus.D2[31]}}, bus.D2});
        prod   = bus.op[0] ? prod_u : prod_s;
    end

    // Quotient/remainder; a zero divisor is replaced by 1 so the divider
    // stays defined, and the result is then dropped via wr_en.
    always_comb begin
        div_ok  = (bus.D2 != 32'd0);
        divisor = div_ok ? bus.D2 : 32'd1;
        div_ovf = (bus.D1 == 32'h8000_0000) && (bus.D2 == 32'hFFFF_FFFF);
        if (bus.op[0]) begin
            quo = bus.D1 / divisor;
            rem = bus.D1 % divisor;
        end else if (div_ovf) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else begin
            quo = $signed(bus.D1) / $signed(divisor);
            rem = $signed(bus.D1) % $signed(divisor);
        end
    end

    // Sequencer FSM: accept in IDLE, count down in RUN, commit on the last count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            wr_en  <= 1'b0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        case (bus.op)
                            3'd0, 3'd1: begin
                                res_hi <= prod[63:32];
                                res_lo <= prod[31:0];
                                wr_en  <= 1'b1;
                                cnt    <= MULT_CNT;
                                state  <= RUN;
                            end
                            3'd2, 3'd3: begin
                                res_hi <= rem;
                                res_lo <= quo;
                                wr_en  <= div_ok;
                                cnt    <= DIV_CNT;
                                state  <= RUN;
                            end
                            3'd4:    hi_q <= bus.D1;
                            3'd5:    lo_q <= bus.D1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        if (wr_en) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vector table, randomized ops against a
// reference model, and hand sequences for stall/back-to-back and mid-RUN reset.
module tb_md_sequencer;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic clk;
    logic reset;
    md_sequencer_if bus();

    md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    // model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.op_valid = 1'b0;
        bus.op       = 3'd7;
        bus.D1       = 32'd0;
        bus.D2       = 32'd0;
        bus.exc_int  = 1'b0;
        bus.md_use_D = 1'b0;
    endtask

    // Reference: what HI/LO become and how long the unit is busy.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input bit exc, inout logic [31:0] hi, inout logic [31:0] lo,
                                  output int lat, output bit st);
        longint p, q, r;
        logic [63:0] pu;
        lat = 0;
        st  = 0;
        if (exc || op > 3'd5) return;
        case (op)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                hi = p[63:32]; lo = p[31:0]; lat = MULT_LAT; st = 1;
            end
            3'd1: begin
                pu = {32'b0, a} * {32'b0, b};
                hi = pu[63:32]; lo = pu[31:0]; lat = MULT_LAT; st = 1;
            end
            3'd2: begin
                if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    lo = q[31:0]; hi = r[31:0];
                end
                lat = DIV_LAT; st = 1;
            end
            3'd3: begin
                if (b != 0) begin
                    lo = a / b; hi = a % b;
                end
                lat = DIV_LAT; st = 1;
            end
            3'd4: hi = a;
            default: lo = a;
        endcase
    endfunction

    // Present one op for a single cycle, then measure busy length and HI/LO.
    task automatic apply(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit exc, input logic [31:0] e_hi,
                         input logic [31:0] e_lo, input int e_lat, input bit e_start);
        int n;
        logic [63:0] e;
        exp_q.push_back({e_hi, e_lo});
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = op; bus.D1 = a; bus.D2 = b; bus.exc_int = exc;
        #1;
        check({name, ".start"}, 64'(bus.start), 64'(e_start));
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({name, ".busy_cycles"}, 64'(n), 64'(e_lat));
        e = exp_q.pop_front();
        check({name, ".hilo"}, {bus.HI, bus.LO}, e);
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        bit          exc;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        int          e_lat;
        bit          e_start;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat;
        bit st;
        int n;
        logic [2:0] op;
        logic [31:0] a, b;
        bit exc;

        vecs[0]  = '{"mult_neg",   3'd0, 32'hFFFFFFFD, 32'd7,        0, 32'hFFFFFFFF, 32'hFFFFFFEB, 5,  1};
        vecs[1]  = '{"multu_max",  3'd1, 32'hFFFFFFFF, 32'd2,        0, 32'h00000001, 32'hFFFFFFFE, 5,  1};
        vecs[2]  = '{"div_neg",    3'd2, 32'hFFFFFFF9, 32'd2,        0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1};
        vecs[3]  = '{"divu_zero",  3'd3, 32'd7,        32'd0,        0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1};
        vecs[4]  = '{"mthi",       3'd4, 32'h12345678, 32'd0,        0, 32'h12345678, 32'hFFFFFFFD, 0,  0};
        vecs[5]  = '{"mthi_exc",   3'd4, 32'hDEADBEEF, 32'd0,        1, 32'h12345678, 32'hFFFFFFFD, 0,  0};
        vecs[6]  = '{"mtlo",       3'd5, 32'hCAFEF00D, 32'd0,        0, 32'h12345678, 32'hCAFEF00D, 0,  0};
        vecs[7]  = '{"div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 32'h00000000, 32'h80000000, 10, 1};
        vecs[8]  = '{"op6_ignore", 3'd6, 32'h55555555, 32'd3,        0, 32'h00000000, 32'h80000000, 0,  0};
        vecs[9]  = '{"divu",       3'd3, 32'd100,      32'd7,        0, 32'h00000002, 32'h0000000E, 10, 1};
        vecs[10] = '{"div_negdiv", 3'd2, 32'd7,        32'hFFFFFFFE, 0, 32'h00000001, 32'hFFFFFFFD, 10, 1};
        vecs[11] = '{"mult_exc",   3'd0, 32'd9,        32'd9,        1, 32'h00000001, 32'hFFFFFFFD, 0,  0};

        // reset: start/stall held low even with an op and a D-stage user present
        idle_inputs();
        reset = 1'b0;
        bus.op_valid = 1'b1; bus.op = 3'd0; bus.md_use_D = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.start", 64'(bus.start), 64'd0);
        check("rst.stall", 64'(bus.stall_md), 64'd0);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        check("rst.busy", 64'(bus.busy), 64'd0);
        check("rst.hilo", {bus.HI, bus.LO}, 64'd0);

        // directed table
        for (int i = 0; i < 12; i++)
            apply(vecs[i].name, vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].exc,
                  vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_lat, vecs[i].e_start);
        m_hi = bus.HI; // resynchronise model to the table's final expectation
        m_lo = bus.LO;
        m_hi = vecs[11].e_hi;
        m_lo = vecs[11].e_lo;

        // randomized ops against the model
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom();
            b   = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            exc = ($urandom_range(0, 7) == 0);
            model(op, a, b, exc, m_hi, m_lo, lat, st);
            apply("rand", op, a, b, exc, m_hi, m_lo, lat, st);
        end

        // mult held in E while busy, D-stage user stalls; second op starts on the fall
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd0; bus.D1 = 32'd6; bus.D2 = 32'hFFFFFFFE; bus.md_use_D = 1'b1;
        #1;
        check("b2b.start1", 64'(bus.start), 64'd1);
        check("b2b.stall_start", 64'(bus.stall_md), 64'd1);
        model(3'd0, 32'd6, 32'hFFFFFFFE, 0, m_hi, m_lo, lat, st);
        exp_q.push_back({m_hi, m_lo});
        @(negedge clk);
        bus.op = 3'd1; bus.D1 = 32'h10000; bus.D2 = 32'h30000;
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            if (!(bus.stall_md === 1'b1 && bus.start === 1'b0)) check("b2b.stall_run", {bus.stall_md, bus.start}, 2'b10);
            @(negedge clk);
        end
        check("b2b.busy1", 64'(n), 64'(MULT_LAT));
        check("b2b.hilo1", {bus.HI, bus.LO}, exp_q.pop_front());
        #1;
        check("b2b.start2", 64'(bus.start), 64'd1);
        check("b2b.stall_fall", 64'(bus.stall_md), 64'd1);
        model(3'd1, 32'h10000, 32'h30000, 0, m_hi, m_lo, lat, st);
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("b2b.busy2", 64'(n), 64'(MULT_LAT));
        check("b2b.hilo2", {bus.HI, bus.LO}, {m_hi, m_lo});

        // reset during the 3rd busy cycle of a div discards it
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op = 3'd2; bus.D1 = 32'd50; bus.D2 = 32'd5;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rstrun.busy3", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        bus.md_use_D = 1'b1;
        #1;
        check("rstrun.stall", 64'(bus.stall_md), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.md_use_D = 1'b0;
        check("rstrun.busy", 64'(bus.busy), 64'd0);
        check("rstrun.hilo", {bus.HI, bus.LO}, 64'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        model(3'd1, 32'd3, 32'd4, 0, m_hi, m_lo, lat, st);
        apply("after_rst", 3'd1, 32'd3, 32'd4, 0, m_hi, m_lo, lat, st);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
